debug_sequencer: RTL and testbench

//  CPU-side controller for the debug port. Halts the core at an instruction boundary on DEBUG_STOP, then executes one debug op per DEBUG_REQ.

---
 rtl/debug_sequencer_pkg.sv | 31 +++
 rtl/debug_sequencer_if.sv | 28 ++
 rtl/debug_sequencer_bus_timer.sv | 13 +
 rtl/debug_sequencer.sv | 66 ++++++
 tb/tb_debug_sequencer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/debug_sequencer_pkg.sv
// debug_sequencer_pkg: op codes, capture-mux selects, FSM states and op decode helpers
package debug_sequencer_pkg;
   localparam logic [2:0] DEBUG_OP_NOP    = 3'd0;
   localparam logic [2:0] DEBUG_OP_MEM_RD = 3'd1;
   localparam logic [2:0] DEBUG_OP_MEM_WR = 3'd2;
   localparam logic [2:0] DEBUG_OP_REG_RD = 3'd3;
   localparam logic [2:0] DEBUG_OP_CC_RD  = 3'd4;
   localparam logic [2:0] DEBUG_OP_PC_RD  = 3'd5;
   localparam logic [1:0] DEBUG_DATAX_DIN       = 2'd0;
   localparam logic [1:0] DEBUG_DATAX_REGB_DATA = 2'd1;
   localparam logic [1:0] DEBUG_DATAX_CC_DATA   = 2'd2;
   localparam logic [1:0] DEBUG_DATAX_PC_A_NEXT = 2'd3;
   typedef enum logic [2:0] {
      ST_RUN, ST_HALT_WAIT, ST_HALTED, ST_EXEC, ST_CAPTURE, ST_ACK
   } dbg_state_t;
   function automatic logic is_mem(input logic [2:0] c);
      return c == DEBUG_OP_MEM_RD || c == DEBUG_OP_MEM_WR;
   endfunction
   function automatic logic is_read(input logic [2:0] c);
      return c inside {DEBUG_OP_MEM_RD, DEBUG_OP_REG_RD, DEBUG_OP_CC_RD, DEBUG_OP_PC_RD};
   endfunction
   // codes 6-7 fall outside this range and behave as NOP
   function automatic logic is_op(input logic [2:0] c);
      return c inside {[DEBUG_OP_MEM_RD:DEBUG_OP_PC_RD]};
   endfunction
   function automatic logic [1:0] datax_sel(input logic [2:0] c);
      return c == DEBUG_OP_REG_RD ? DEBUG_DATAX_REGB_DATA :
             c == DEBUG_OP_CC_RD  ? DEBUG_DATAX_CC_DATA   :
             c == DEBUG_OP_PC_RD  ? DEBUG_DATAX_PC_A_NEXT : DEBUG_DATAX_DIN;
   endfunction
endpackage

// File: rtl/debug_sequencer_if.sv
// debug_sequencer_if: debug port, core halt and debug bus signals of the sequencer
interface debug_sequencer_if;
   logic       i_debug_stop;
   logic       i_debug_req;
   logic [3:0] i_debug_op;
   logic       i_instr_boundary;
   logic       i_bus_rdy;
   logic       o_debug_ack;
   logic       o_cpu_halt;
   logic       o_debug_halted;
   logic       o_bus_req;
   logic       o_bus_wr;
   logic       o_regb_rd_en;
   logic [1:0] o_debug_datax;
   logic       o_debug_ld_data_en;
   logic       o_debug_addr_inc_en;
   logic       o_debug_err;
   modport slave(
      input  i_debug_stop, i_debug_req, i_debug_op, i_instr_boundary, i_bus_rdy,
      output o_debug_ack, o_cpu_halt, o_debug_halted, o_bus_req, o_bus_wr, o_regb_rd_en,
             o_debug_datax, o_debug_ld_data_en, o_debug_addr_inc_en, o_debug_err
   );
   modport master(
      output i_debug_stop, i_debug_req, i_debug_op, i_instr_boundary, i_bus_rdy,
      input  o_debug_ack, o_cpu_halt, o_debug_halted, o_bus_req, o_bus_wr, o_regb_rd_en,
             o_debug_datax, o_debug_ld_data_en, o_debug_addr_inc_en, o_debug_err
   );
endinterface

// File: rtl/debug_sequencer_bus_timer.sv
// debug_bus_timer: counts bus-wait cycles while i_run is high; flags the last allowed cycle
module debug_bus_timer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_run,
   output logic o_expired
);
   logic [7:0] r_cnt;
   always_ff @(posedge i_clk) r_cnt <= (i_rst || !i_run) ? 8'd0 : r_cnt + 8'd1;
   assign o_expired = i_run && r_cnt == 8'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/debug_sequencer.sv
// debug_sequencer: halts the core at an instruction boundary and runs one debug op per 4-phase request
module debug_sequencer
  import debug_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic              i_clk,
  input logic              i_rst,
  debug_sequencer_if.slave io_dbg
);
  dbg_state_t r_state, w_next;
  logic [3:0] r_op;
  logic [1:0] r_datax;
  logic       r_err;
  logic [2:0] w_code;
  logic       w_mem, w_read, w_timeout, w_live, w_accept;
  assign w_code   = r_op[3:1];
  assign w_mem    = is_mem(w_code);
  assign w_read   = is_read(w_code);
  assign w_live   = !i_rst;
  assign w_accept = r_state == ST_HALTED && io_dbg.i_debug_req;
`ifdef DEBUG_TIMEOUT_EN
  logic w_expired;
  debug_bus_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .i_clk(i_clk), .i_rst(i_rst), .i_run(r_state == ST_EXEC && w_mem), .o_expired(w_expired)
  );
  assign w_timeout = w_expired && !io_dbg.i_bus_rdy;
`else
  assign w_timeout = 1'b0;
`endif
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_RUN;
      r_op    <= 4'd0;
      r_datax <= DEBUG_DATAX_DIN;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_op <= io_dbg.i_debug_op;
      if (r_state == ST_EXEC && w_next == ST_CAPTURE && w_read) r_datax <= datax_sel(w_code);
      r_err <= w_accept ? 1'b0 : r_err | w_timeout;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN:       w_next = io_dbg.i_debug_stop ? ST_HALT_WAIT : ST_RUN;
      ST_HALT_WAIT: w_next = !io_dbg.i_debug_stop ? ST_RUN : io_dbg.i_instr_boundary ? ST_HALTED : ST_HALT_WAIT;
      ST_HALTED:    w_next = io_dbg.i_debug_req ? ST_EXEC : !io_dbg.i_debug_stop ? ST_RUN : ST_HALTED;
      ST_EXEC:      w_next = w_timeout ? ST_ACK : (!w_mem || io_dbg.i_bus_rdy) ? ST_CAPTURE : ST_EXEC;
      ST_CAPTURE:   w_next = ST_ACK;
      ST_ACK:       w_next = io_dbg.i_debug_req ? ST_ACK : ST_HALTED;
      default:      w_next = ST_RUN;
    endcase
    io_dbg.o_cpu_halt          = w_live && r_state inside {ST_HALTED, ST_EXEC, ST_CAPTURE, ST_ACK};
    io_dbg.o_debug_halted      = io_dbg.o_cpu_halt;
    io_dbg.o_bus_req           = w_live && r_state == ST_EXEC && w_mem;
    io_dbg.o_bus_wr            = io_dbg.o_bus_req && w_code == DEBUG_OP_MEM_WR;
    io_dbg.o_regb_rd_en        = w_live && r_state == ST_EXEC && w_code == DEBUG_OP_REG_RD;
    io_dbg.o_debug_ld_data_en  = w_live && r_state == ST_CAPTURE && w_read;
    io_dbg.o_debug_addr_inc_en = w_live && r_state == ST_CAPTURE && r_op[0] && is_op(w_code);
    io_dbg.o_debug_ack         = w_live && r_state == ST_ACK;
    io_dbg.o_debug_datax       = r_datax;
    io_dbg.o_debug_err         = r_err;
  end
endmodule

// File: tb/tb_debug_sequencer.sv
// tb_debug_sequencer: transaction-scripted expectations per cycle, randomized ops/waits/holds
module tb_debug_sequencer;
  localparam int T = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  debug_sequencer_if ifc();
  debug_sequencer #(.TIMEOUT_CYCLES(T)) u_dut (
    .i_clk(clk), .i_rst(rst), .io_dbg(ifc)
  );
  int cyc = 0, tests = 0, fails = 0;
  int t_req = 0, t_ack = 0, n_ld = 0, n_inc = 0;
  logic chk = 1'b0, p_ack = 1'b0;
  logic e_halt, e_ack, e_br, e_bw, e_rg, e_ld, e_inc, e_err;
  logic [1:0] e_dx;
  logic m_h = 1'b0, m_err = 1'b0;
  logic [1:0] m_dx = 2'd0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (chk) begin
      cmp("cpu_halt", ifc.o_cpu_halt, e_halt);
      cmp("debug_halted", ifc.o_debug_halted, e_halt);
      cmp("ack", ifc.o_debug_ack, e_ack);
      cmp("bus_req", ifc.o_bus_req, e_br);
      cmp("bus_wr", ifc.o_bus_wr, e_bw);
      cmp("regb_rd_en", ifc.o_regb_rd_en, e_rg);
      cmp("ld_data_en", ifc.o_debug_ld_data_en, e_ld);
      cmp("addr_inc_en", ifc.o_debug_addr_inc_en, e_inc);
      cmp("datax", ifc.o_debug_datax, e_dx);
      cmp("err", ifc.o_debug_err, e_err);
    end
    if (ifc.o_debug_ack === 1'b1 && !p_ack) t_ack = cyc;
    if (ifc.o_debug_ld_data_en === 1'b1) n_ld++;
    if (ifc.o_debug_addr_inc_en === 1'b1) n_inc++;
    p_ack = ifc.o_debug_ack === 1'b1;
  end
  task automatic nxt();
    @(posedge clk);
    #1;
    ifc.i_bus_rdy = 1'($urandom);
    ifc.i_instr_boundary = 1'($urandom);
    ifc.i_debug_op = 4'($urandom);
    e_halt = m_h; e_ack = 0; e_br = 0; e_bw = 0; e_rg = 0; e_ld = 0; e_inc = 0;
    e_dx = m_dx; e_err = m_err; chk = 1'b1;
  endtask
  task automatic halt(input int n, input bit abort);
    nxt();
    ifc.i_debug_stop = 1'b1;
    for (int i = 0; i < n; i++) begin
      nxt();
      ifc.i_instr_boundary = 1'b0;
    end
    nxt();
    if (abort) begin
      ifc.i_debug_stop = 1'b0;
      ifc.i_instr_boundary = 1'b0;
    end else begin
      ifc.i_instr_boundary = 1'b1;
      m_h = 1'b1;
    end
  endtask
  task automatic unhalt();
    nxt();
    ifc.i_debug_stop = 1'b0;
    ifc.i_debug_req = 1'b0;
    m_h = 1'b0;
  endtask
  task automatic do_op(input logic [3:0] op, input int w, input int hold, input bit drop_stop);
    logic [2:0] c;
    bit mem, rd, inc, to;
    logic [1:0] sel;
    int n;
    c = op[3:1];
    mem = c == 3'd1 || c == 3'd2;
    rd = c == 3'd1 || (c >= 3'd3 && c <= 3'd5);
    inc = op[0] && c >= 3'd1 && c <= 3'd5;
    sel = c == 3'd1 ? 2'd0 : 2'(c - 3'd2);
`ifdef DEBUG_TIMEOUT_EN
    to = mem && w >= T;
`else
    to = 1'b0;
`endif
    nxt();
    ifc.i_debug_req = 1'b1;
    ifc.i_debug_op = op;
    if (drop_stop) ifc.i_debug_stop = 1'b0;
    t_req = cyc;
    m_err = 1'b0;
    n = !mem ? 1 : to ? T : w + 1;
    for (int e = 0; e < n; e++) begin
      nxt();
      if (mem) ifc.i_bus_rdy = e == w;
      e_br = mem; e_bw = c == 3'd2; e_rg = c == 3'd3;
    end
    if (to) m_err = 1'b1;
    else begin
      if (rd) m_dx = sel;
      nxt();
      e_ld = rd; e_inc = inc;
    end
    for (int k = 0; k <= hold; k++) begin
      nxt();
      e_ack = 1'b1;
      if (k == hold) ifc.i_debug_req = 1'b0;
    end
    @(negedge clk);
    #1;
  endtask
  initial begin
    int l0, i0;
    ifc.i_debug_stop = 0; ifc.i_debug_req = 0; ifc.i_debug_op = 0;
    ifc.i_instr_boundary = 0; ifc.i_bus_rdy = 0;
    repeat (2) @(posedge clk);
    nxt();
    e_halt = 0;
    nxt();
    rst = 1'b0;
    halt(2, 1);
    halt(4, 0);
    unhalt();
    halt(0, 0);
    do_op(4'h3, 2, 1, 0);
    cmp("lat_mem_w2", t_ack - t_req, 5);
    l0 = n_ld;
    do_op(4'h6, 0, 0, 0);
    cmp("lat_reg", t_ack - t_req, 3);
    cmp("ld_reg", n_ld - l0, 1);
    l0 = n_ld; i0 = n_inc;
    repeat (3) do_op(4'h5, $urandom_range(0, 2), 3, 0);
    cmp("inc_wr3", n_inc - i0, 3);
    cmp("ld_wr3", n_ld - l0, 0);
    do_op(4'h8, 0, 0, 0);
    cmp("lat_cc", t_ack - t_req, 3);
    do_op(4'hB, 0, 2, 0);
    do_op(4'h1, 0, 0, 0);
    i0 = n_inc;
    do_op(4'hD, 0, 0, 0);
    cmp("inc_op6", n_inc - i0, 0);
    do_op(4'h2, 0, 0, 0);
    cmp("lat_mem_w0", t_ack - t_req, 3);
`ifdef DEBUG_TIMEOUT_EN
    l0 = n_ld;
    do_op(4'h3, 10, 1, 0);
    cmp("timeout_ld", n_ld - l0, 0);
    do_op(4'h6, 0, 0, 0);
`endif
    do_op(4'h6, 0, 0, 1);
    unhalt();
    halt(1, 0);
    nxt();
    ifc.i_debug_req = 1'b1; ifc.i_debug_op = 4'h2; m_err = 1'b0;
    for (int e = 0; e < 2; e++) begin
      nxt();
      ifc.i_bus_rdy = 1'b0; e_br = 1'b1;
    end
    nxt();
    ifc.i_bus_rdy = 1'b0; rst = 1'b1; e_halt = 1'b0; m_h = 1'b0;
    m_dx = 2'd0; m_err = 1'b0;
    nxt();
    rst = 1'b0; ifc.i_debug_req = 1'b0; ifc.i_debug_stop = 1'b0;
    for (int r = 0; r < 30; r++) begin
      bit ab;
      ab = $urandom_range(0, 3) == 0;
      halt($urandom_range(0, 3), ab);
      if (!ab) begin
        repeat ($urandom_range(1, 4)) do_op(4'($urandom), $urandom_range(0, 6), $urandom_range(0, 2), 0);
        if ($urandom_range(0, 1) == 1) do_op(4'($urandom), $urandom_range(0, 6), $urandom_range(0, 2), 1);
        unhalt();
      end
      repeat ($urandom_range(0, 2)) nxt();
    end
    nxt();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
